dispatch_queue: RTL and testbench

- Instruction dispatch FIFO between the decode stage and one reservation station instance.
- Buffers decoded instruction bundles (queueWidth bits each) and absorbs the reservation station's full/stall back-pressure, so decode does not stall on every full cycle.
- Issues at most one bundle per cycle to the reservation station through a registered enable/data pair.

---
 rtl/dispatch_queue_if.sv | 27 ++
 rtl/dispatch_queue.sv | 106 ++++++++++
 tb/tb_dispatch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_if.sv
// Handshake bundle between decode, the dispatch queue and the reservation station.
// Parameters must match those of the dispatch_queue instance that uses it.
interface dispatch_queue_if #(
  parameter int queueWidth = 302,
  parameter int DQIdxBits  = 3
);
  logic                  flush_i;
  logic                  enable_i;
  logic [queueWidth-1:0] inst_i;
  logic                  rsFull_i;
  logic                  stall_o;
  logic                  enable_o;
  logic [queueWidth-1:0] inst_o;
  logic [DQIdxBits:0]    count_o;

  // Decode / pipeline-control side: drives the bundle and flush, observes the issue port.
  modport master (
    output flush_i, enable_i, inst_i, rsFull_i,
    input  stall_o, enable_o, inst_o, count_o
  );

  // Queue side.
  modport slave (
    input  flush_i, enable_i, inst_i, rsFull_i,
    output stall_o, enable_o, inst_o, count_o
  );
endinterface

// File: rtl/dispatch_queue.sv
// Instruction dispatch FIFO between decode and one reservation station.
// Holds 2**DQIdxBits decoded bundles and issues at most one per cycle through a
// registered enable/data pair, absorbing reservation-station back-pressure.
// Optional feature: define DQ_BYPASS_EN to let a bundle arriving at an empty,
// unblocked queue go straight to the output register (1-cycle latency).
module dispatch_queue #(
  parameter int queueWidth = 302,
  parameter int DQIdxBits  = 3,
  parameter int DQInstance = 0
) (
  input logic             clock_i,
  input logic             reset_i,
  dispatch_queue_if.slave dq
);

  localparam int Depth = 2 ** DQIdxBits;
  localparam logic [DQIdxBits:0] FullCount = (DQIdxBits+1)'(Depth);

  logic [queueWidth-1:0] r_mem [Depth];
  logic [DQIdxBits-1:0]  r_wrPtr;
  logic [DQIdxBits-1:0]  r_rdPtr;
  logic [DQIdxBits:0]    r_count;
  logic                  r_enable;
  logic [queueWidth-1:0] r_inst;

  logic w_full;
  logic w_pushReq;
  logic w_pop;
  logic w_bypass;
  logic w_push;

  // The instance number only selects debug logging; no hardware depends on it.
  if (DQInstance < 0) begin : g_invalidInstance
  end

  // Full is decoded from the count register, so it reflects only the start-of-cycle state
  // and a full queue needs one drained cycle before it accepts again.
  assign w_full    = (r_count == FullCount);
  assign w_pushReq = dq.enable_i && !w_full && !dq.flush_i;
  assign w_pop     = (r_count != '0) && !dq.rsFull_i && !dq.flush_i;

`ifdef DQ_BYPASS_EN
  assign w_bypass  = (r_count == '0) && dq.enable_i && !dq.rsFull_i && !dq.flush_i;
`else
  assign w_bypass  = 1'b0;
`endif

  // A bypassed bundle never touches the array.
  assign w_push = w_pushReq && !w_bypass;

  // Storage array: written only on an accepted push; contents need no reset.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= dq.inst_i;
    end
  end

  // Pointers and occupancy; flush drops everything, including a same-cycle push or pop.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (dq.flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + DQIdxBits'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + DQIdxBits'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DQIdxBits+1)'(1);
        2'b01:   r_count <= r_count - (DQIdxBits+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered issue port: one enable pulse per transferred bundle, data held otherwise.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_enable <= 1'b0;
      r_inst   <= '0;
    end else if (dq.flush_i) begin
      r_enable <= 1'b0;
    end else if (w_pop) begin
      r_enable <= 1'b1;
      r_inst   <= r_mem[r_rdPtr];
    end else if (w_bypass) begin
      r_enable <= 1'b1;
      r_inst   <= dq.inst_i;
    end else begin
      r_enable <= 1'b0;
    end
  end

  assign dq.stall_o  = w_full;
  assign dq.enable_o = r_enable;
  assign dq.inst_o   = r_inst;
  assign dq.count_o  = r_count;

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: a reference model with an expected-bundle
// queue checks every cycle, plus a table of fill/drain vectors and hand-written
// sequences for latency, wrap-around, flush and asynchronous reset.
module tb_dispatch_queue;

  localparam int QW    = 302;
  localparam int IB    = 3;
  localparam int DEPTH = 8;
  localparam int NVEC  = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  dispatch_queue_if #(.queueWidth(QW), .DQIdxBits(IB)) dqIf ();

  dispatch_queue #(.queueWidth(QW), .DQIdxBits(IB), .DQInstance(0)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .dq      (dqIf)
  );

  typedef struct {
    logic          en;
    logic [QW-1:0] inst;
    logic          rsFull;
    logic          expEnable;
    logic [QW-1:0] expInst;
    logic [IB:0]   expCount;
    logic          expStall;
  } vec_t;

  vec_t          vecs [NVEC];
  logic [QW-1:0] sb [$];
  int            modelCount = 0;
  int            nCompared  = 0;
  int            nMismatch  = 0;

  // Distinct wide bundle so upper bits are exercised too.
  function automatic logic [QW-1:0] bundle(input int i);
    return {32'hC0DE_0000 | 32'(i), 270'(i * 7 + 3)};
  endfunction

  // One comparison; prints a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, then check
  // the DUT just after the rising edge against the model's expectations.
  task automatic applyStimulus(input logic en, input logic [QW-1:0] data,
                               input logic rsf, input logic fl);
    logic          expEn;
    logic [QW-1:0] expData;
    logic          pushOk;
    logic          popOk;
    logic          bypass;
    @(negedge clk);
    dqIf.enable_i = en;
    dqIf.inst_i   = data;
    dqIf.rsFull_i = rsf;
    dqIf.flush_i  = fl;
    expEn   = 1'b0;
    expData = '0;
    if (fl) begin
      sb.delete();
      modelCount = 0;
    end else begin
      pushOk = en && (modelCount != DEPTH);
      popOk  = (modelCount != 0) && !rsf;
      bypass = 1'b0;
`ifdef DQ_BYPASS_EN
      bypass = (modelCount == 0) && en && !rsf;
`endif
      if (bypass) begin
        expEn   = 1'b1;
        expData = data;
      end else begin
        if (popOk) begin
          expEn   = 1'b1;
          expData = sb.pop_front();
        end
        if (pushOk) sb.push_back(data);
        modelCount = modelCount + int'(pushOk) - int'(popOk);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("enable_o", QW'(dqIf.enable_o), QW'(expEn));
    checkOutput("count_o", QW'(dqIf.count_o), QW'(modelCount));
    checkOutput("stall_o", QW'(dqIf.stall_o), QW'(modelCount == DEPTH));
    if (expEn) checkOutput("inst_o", dqIf.inst_o, expData);
  endtask

  // Main sequence.
  initial begin
    dqIf.enable_i = 1'b0;
    dqIf.inst_i   = '0;
    dqIf.rsFull_i = 1'b0;
    dqIf.flush_i  = 1'b0;

    // Fill-while-blocked then drain-in-order vectors.
    for (int i = 0; i < 9; i++) begin
      vecs[i].en        = 1'b1;
      vecs[i].inst      = QW'(i + 1);
      vecs[i].rsFull    = 1'b1;
      vecs[i].expEnable = 1'b0;
      vecs[i].expInst   = '0;
      vecs[i].expCount  = (i < DEPTH) ? (IB+1)'(i + 1) : (IB+1)'(DEPTH);
      vecs[i].expStall  = (i >= DEPTH - 1);
    end
    for (int k = 0; k < 8; k++) begin
      vecs[9+k].en        = 1'b0;
      vecs[9+k].inst      = '0;
      vecs[9+k].rsFull    = 1'b0;
      vecs[9+k].expEnable = 1'b1;
      vecs[9+k].expInst   = QW'(k + 1);
      vecs[9+k].expCount  = (IB+1)'(DEPTH - 1 - k);
      vecs[9+k].expStall  = 1'b0;
    end
    vecs[17].en        = 1'b0;
    vecs[17].inst      = '0;
    vecs[17].rsFull    = 1'b0;
    vecs[17].expEnable = 1'b0;
    vecs[17].expInst   = '0;
    vecs[17].expCount  = '0;
    vecs[17].expStall  = 1'b0;

    // Reset state, checked between edges while reset is held.
    #12;
    checkOutput("resetEnable", QW'(dqIf.enable_o), '0);
    checkOutput("resetInst", dqIf.inst_o, '0);
    checkOutput("resetCount", QW'(dqIf.count_o), '0);
    checkOutput("resetStall", QW'(dqIf.stall_o), '0);
    @(negedge clk);
    rst = 1'b0;

    // Single push of 0x..A5 and its decode-to-RS latency.
    applyStimulus(1'b1, {32'hDEADBEEF, 262'h0, 8'hA5}, 1'b0, 1'b0);
`ifdef DQ_BYPASS_EN
    checkOutput("latency1Enable", QW'(dqIf.enable_o), QW'(1));
`else
    checkOutput("latency1Enable", QW'(dqIf.enable_o), QW'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("latency2Enable", QW'(dqIf.enable_o), QW'(1));
`endif
    checkOutput("latencyInst", dqIf.inst_o, {32'hDEADBEEF, 262'h0, 8'hA5});
    checkOutput("latencyCount", QW'(dqIf.count_o), '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Table-driven fill / ignored ninth push / ordered drain.
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].en, vecs[v].inst, vecs[v].rsFull, 1'b0);
      checkOutput($sformatf("vec%0d.enable", v), QW'(dqIf.enable_o), QW'(vecs[v].expEnable));
      checkOutput($sformatf("vec%0d.count", v), QW'(dqIf.count_o), QW'(vecs[v].expCount));
      checkOutput($sformatf("vec%0d.stall", v), QW'(dqIf.stall_o), QW'(vecs[v].expStall));
      if (vecs[v].expEnable) checkOutput($sformatf("vec%0d.inst", v), dqIf.inst_o, vecs[v].expInst);
    end

    // Wrap-around: three pre-loads, then push and pop every cycle for 20 cycles.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, bundle(100 + i), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, bundle(200 + i), 1'b0, 1'b0);
      checkOutput("steadyCount", QW'(dqIf.count_o), QW'(3));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Flush with five queued plus a same-cycle push; none may ever appear.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, bundle(300 + i), 1'b1, 1'b0);
    checkOutput("preFlushCount", QW'(dqIf.count_o), QW'(5));
    applyStimulus(1'b1, bundle(399), 1'b0, 1'b1);
    checkOutput("flushCount", QW'(dqIf.count_o), '0);
    checkOutput("flushEnable", QW'(dqIf.enable_o), '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset between edges while a drain is issuing.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, bundle(400 + i), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("preResetEnable", QW'(dqIf.enable_o), QW'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetEnable", QW'(dqIf.enable_o), '0);
    checkOutput("asyncResetCount", QW'(dqIf.count_o), '0);
    checkOutput("asyncResetStall", QW'(dqIf.stall_o), '0);
    sb.delete();
    modelCount = 0;
    dqIf.enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // First push after release sees the normal latency.
    applyStimulus(1'b1, bundle(500), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
